adc_matrix_reader: RTL

//  Frame reader for the ADC sample accumulator. The accumulator fills an N x M matrix and pulses a ready strobe.

---
 rtl/adc_matrix_reader.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/adc_matrix_reader.sv
// adc_matrix_reader: snapshots the N x M ADC accumulator matrix on a rising
// mat_ready and streams it element by element (row-major) over valid/ready.
// Optional per-row signed sum is enabled by defining ROW_SUM_EN.
module adc_matrix_reader #(
    parameter int N      = 8,
    parameter int M      = 512,
    parameter int DATA_W = 32
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [N-1:0][M-1:0][DATA_W-1:0]      mat_in,
    input  logic                                 mat_ready,
    output logic [DATA_W-1:0]                    out_data,
    output logic [$clog2(N)-1:0]                 out_row,
    output logic [$clog2(M)-1:0]                 out_col,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic                                 out_last_row,
    output logic                                 out_last,
    output logic                                 busy,
    output logic                                 frame_done,
    output logic                                 overrun,
    input  logic                                 clear_overrun,
    output logic [DATA_W+$clog2(M)-1:0]          row_sum,
    output logic                                 row_sum_valid
);
    localparam int RW = $clog2(N);
    localparam int CW = $clog2(M);

    typedef enum logic [1:0] {IDLE, CAPTURE, STREAM, DONE} state_t;

    state_t                          state_q, state_d;
    logic                            mr_q, mr_d;
    logic [RW-1:0]                   row_q, row_d;
    logic [CW-1:0]                   col_q, col_d;
    logic                            vld_q, vld_d;
    logic [DATA_W-1:0]               data_q, data_d;
    logic                            overrun_q, overrun_d;
    logic [N-1:0][M-1:0][DATA_W-1:0] snap_q;

    logic          rise, xfer, at_col_end, at_row_end;
    logic [RW-1:0] nxt_row;
    logic [CW-1:0] nxt_col;

    assign rise       = mat_ready & ~mr_q;
    assign xfer       = vld_q & out_ready;
    assign at_col_end = (col_q == CW'(M - 1));
    assign at_row_end = (row_q == RW'(N - 1));
    assign nxt_col    = at_col_end ? '0 : col_q + 1'b1;
    assign nxt_row    = at_col_end ? row_q + 1'b1 : row_q;

    // Next-state, index and output-register logic; all outputs come from flops
    // so out_ready never reaches an output combinationally.
    always_comb begin
        state_d   = state_q;
        mr_d      = mat_ready;
        row_d     = row_q;
        col_d     = col_q;
        vld_d     = vld_q;
        data_d    = data_q;
        overrun_d = overrun_q;

        // Set wins over a simultaneous clear.
        if (rise && state_q != IDLE)
            overrun_d = 1'b1;
        else if (clear_overrun)
            overrun_d = 1'b0;

        case (state_q)
            IDLE: begin
                vld_d = 1'b0;
                if (rise)
                    state_d = CAPTURE;
            end
            CAPTURE: begin
                row_d   = '0;
                col_d   = '0;
                state_d = STREAM;
            end
            STREAM: begin
                if (!vld_q) begin
                    // First element: snapshot was written at the previous edge.
                    vld_d  = 1'b1;
                    data_d = snap_q[row_q][col_q];
                end else if (xfer) begin
                    if (at_col_end && at_row_end) begin
                        // Indices stay at the last element; cleared on next capture.
                        vld_d   = 1'b0;
                        state_d = DONE;
                    end else begin
                        row_d  = nxt_row;
                        col_d  = nxt_col;
                        data_d = snap_q[nxt_row][nxt_col];
                    end
                end
            end
            DONE: begin
                vld_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            mr_q      <= 1'b0;
            row_q     <= '0;
            col_q     <= '0;
            vld_q     <= 1'b0;
            data_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mr_q      <= mr_d;
            row_q     <= row_d;
            col_q     <= col_d;
            vld_q     <= vld_d;
            data_q    <= data_d;
            overrun_q <= overrun_d;
        end
    end

    // Snapshot storage: written only in CAPTURE, never reset (unobservable before a capture).
    always_ff @(posedge clk) begin
        if (state_q == CAPTURE)
            snap_q <= mat_in;
    end

    assign out_valid    = vld_q;
    assign out_data     = data_q;
    assign out_row      = row_q;
    assign out_col      = col_q;
    assign out_last_row = vld_q & at_col_end;
    assign out_last     = vld_q & at_col_end & at_row_end;
    assign busy         = (state_q == CAPTURE) || (state_q == STREAM);
    assign frame_done   = (state_q == DONE);
    assign overrun      = overrun_q;

`ifdef ROW_SUM_EN
    localparam int SW = DATA_W + CW;

    logic [SW-1:0] acc_q, acc_d, rsum_q, rsum_d, acc_sum;
    logic          rsv_q, rsv_d;

    // Row accumulator: restarts at column 0, publishes the full sum on the row's last transfer.
    always_comb begin
        acc_d   = acc_q;
        rsum_d  = rsum_q;
        rsv_d   = 1'b0;
        acc_sum = ((col_q == '0) ? '0 : acc_q) + {{CW{data_q[DATA_W-1]}}, data_q};
        if (xfer) begin
            acc_d = acc_sum;
            if (at_col_end) begin
                rsum_d = acc_sum;
                rsv_d  = 1'b1;
            end
        end
    end

    // Row-sum registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q  <= '0;
            rsum_q <= '0;
            rsv_q  <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            rsum_q <= rsum_d;
            rsv_q  <= rsv_d;
        end
    end

    assign row_sum       = rsum_q;
    assign row_sum_valid = rsv_q;
`else
    assign row_sum       = '0;
    assign row_sum_valid = 1'b0;
`endif

endmodule
